rate_tick_counter: RTL and testbench
====================================

// Module: rate_tick_counter
// PURPOSE
//   Parametrised up/down counter advanced by a programmable-rate tick prescaler.
//   Four divisors are selectable at run time. Adds load, direction and wrap flag.
//   Sits between the board clock and display/LED logic; count[3:0] feeds a hex decoder.
// PARAMETERS
//   WIDTH    8           counter width in bits (1..32)
//   PRESC_W  27          prescaler register width; must hold the largest DIVn-1
//   DIV0     1           divisor for rate_sel=0; 1 = advance every enabled clk
//   DIV1     12500000    divisor for rate_sel=1 (4 Hz at 50 MHz)
//   DIV2     25000000    divisor for rate_sel=2 (2 Hz)
//   DIV3     50000000    divisor for rate_sel=3 (1 Hz)
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-high reset
//   en        in   1        1 = prescaler and counter run; 0 = freeze
//   rate_sel  in   2        divisor select DIV0..DIV3
//   up        in   1        1 = count up, 0 = count down, sampled on terminal cycle
//   load      in   1        synchronous load of load_val
//   load_val  in   WIDTH    value loaded into count
//   count     out  WIDTH    registered counter value
//   tick      out  1        one-clk pulse, high in the cycle count has just advanced
//   wrap      out  1        one-clk pulse on wrap (see CONFIGURATION)
// BEHAVIOUR
//   - reset=1, any time and mid-operation: count=0, prescaler=0, tick=0, wrap=0, sel_q=0
//   - Prescaler counts 0..DIVsel-1 while en=1.
//     term = en & (presc == DIVsel-1).
//   - On the edge where term=1:
//     - presc<=0
//     - count<=count±1
//     - tick<=1
//   - tick and wrap are registered; both are 0 on every cycle that is not the cycle after term.
//   - Latency: the first tick occurs DIVsel enabled cycles after reset release or prescaler clear.
//   - rate_sel is registered into sel_q. When rate_sel != sel_q, presc<=0 and no tick that cycle.
//     The new rate then runs from zero. No partial periods.
//   - Priority, highest first: reset > load > rate change > term.
//   - load=1: count<=load_val, presc<=0, tick<=0, wrap<=0. Works with en=0.
//   - en=0: presc and count hold; tick=0, wrap=0.
//   - Arithmetic is modulo 2^WIDTH:
//     - up at all-ones -> 0, wrap=1
//     - down at 0 -> all-ones, wrap=1
//   - DIVn=1: term is true every enabled cycle, so tick stays high continuously.
//   - DIVn=0 is illegal; the elaboration check fails.
//   - up changing between ticks has no effect until the next term.
// CONFIGURATION
//   RATE_TICK_COUNTER_SAT_EN
//     defined:
//       - the counter saturates at all-ones (up) or 0 (down) instead of wrapping
//       - on a term at the limit, count holds, tick=1, and wrap=1 flags the blocked step
//     undefined:
//       - modulo wrap as above
// TESTING  (sim overrides: DIV0=1 DIV1=2 DIV2=4 DIV3=8, WIDTH=4)
//   1. reset pulse, en=1, sel=2, up=1 -> tick every 4th clk; count 0,1,2,3 on successive ticks
//   2. up=1 from count=15 at a tick -> count=0, wrap=1 for one clk.
//      With SAT_EN: count stays 15, wrap=1.
//   3. load=1 with load_val=9 while term=1 -> count=9, tick=0.
//      Next tick 4 clks later gives count=10.
//   4. sel 3->1 at presc=5 -> presc cleared, no tick that clk.
//      Ticks then every 2 clks.
//   5. en=0 for 10 clks mid-period -> count and presc frozen, tick=0.
//      Resume completes the remaining period.
//   6. reset asserted mid-count asynchronously (no clk edge) -> count=0, tick=0 immediately.
//      up=0 from 0 -> count=15, wrap=1.

Source files
------------

// File: rtl/rate_tick_counter.sv
// Up/down counter advanced by a run-time selectable prescaler (four divisors), with load and wrap flag.
// Optional build macro RATE_TICK_COUNTER_SAT_EN: saturate at the limits instead of wrapping.
module rate_tick_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 27,
  parameter int DIV0    = 1,
  parameter int DIV1    = 12500000,
  parameter int DIV2    = 25000000,
  parameter int DIV3    = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       rate_sel,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  if (DIV0 < 1 || DIV1 < 1 || DIV2 < 1 || DIV3 < 1) begin : g_div_check
    $error("rate_tick_counter: every divisor must be at least 1");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("rate_tick_counter: WIDTH must be in 1..32");
  end

  localparam logic [PRESC_W-1:0] LAST0 = PRESC_W'(DIV0 - 1);
  localparam logic [PRESC_W-1:0] LAST1 = PRESC_W'(DIV1 - 1);
  localparam logic [PRESC_W-1:0] LAST2 = PRESC_W'(DIV2 - 1);
  localparam logic [PRESC_W-1:0] LAST3 = PRESC_W'(DIV3 - 1);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] last;
  logic [1:0]         sel_q;
  logic               term;
  logic               rate_chg;
  logic               at_limit;
  logic [WIDTH-1:0]   count_next;

  always_comb begin
    last = LAST0;
    case (sel_q)
      2'd0: last = LAST0;
      2'd1: last = LAST1;
      2'd2: last = LAST2;
      2'd3: last = LAST3;
      default: last = LAST0;
    endcase
  end

  assign term     = en && (presc == last);
  assign rate_chg = (rate_sel != sel_q);
  assign at_limit = up ? (&count) : (count == '0);

  // Step taken on a terminal cycle; the macro decides whether the limit blocks it.
  always_comb begin
    count_next = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
`ifdef RATE_TICK_COUNTER_SAT_EN
    if (at_limit) count_next = count;
`endif
  end

  // Priority: load, then a rate change (restarts the period), then the terminal step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      presc <= '0;
      sel_q <= 2'd0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      sel_q <= rate_sel;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      if (load) begin
        count <= load_val;
        presc <= '0;
      end else if (rate_chg) begin
        presc <= '0;
      end else if (term) begin
        presc <= '0;
        count <= count_next;
        tick  <= 1'b1;
        wrap  <= at_limit;
      end else if (en) begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rate_tick_counter.sv
// Self-checking bench for rate_tick_counter (WIDTH=4, divisors 1/2/4/8): directed cases plus a
// scoreboard fed by a cycle model; honours RATE_TICK_COUNTER_SAT_EN when defined.
module tb_rate_tick_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   rate_sel = 2'd0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tick;
  logic         wrap;

  rate_tick_counter #(
    .WIDTH(W), .PRESC_W(4), .DIV0(1), .DIV1(2), .DIV2(4), .DIV3(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rate_sel(rate_sel), .up(up),
    .load(load), .load_val(load_val), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];

  // Reference model state
  int           divs[4] = '{1, 2, 4, 8};
  logic [W-1:0] m_count;
  int           m_presc;
  logic [1:0]   m_sel;
  logic         m_tick;
  logic         m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = '0; m_presc = 0; m_sel = 2'd0; m_tick = 1'b0; m_wrap = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic lim;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (load) begin
      m_count = load_val;
      m_presc = 0;
    end else if (rate_sel != m_sel) begin
      m_presc = 0;
    end else if (en && m_presc == divs[m_sel] - 1) begin
      m_presc = 0;
      m_tick  = 1'b1;
      lim = up ? (m_count == 4'hF) : (m_count == 4'h0);
      m_wrap = lim;
`ifdef RATE_TICK_COUNTER_SAT_EN
      if (!lim) m_count = up ? m_count + 4'd1 : m_count - 4'd1;
`else
      m_count = up ? m_count + 4'd1 : m_count - 4'd1;
`endif
    end else if (en) begin
      m_presc = m_presc + 1;
    end
    m_sel = rate_sel;
  endtask

  // One clock: predict, push, let the edge happen, pop and compare just after it.
  task automatic cycle();
    logic [W+1:0] exp;
    model_step();
    exp_q.push_back({m_count, m_tick, m_wrap});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("scoreboard", {26'd0, count, tick, wrap}, {26'd0, exp});
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick && n < 40);
    if (!tick) check("tick_timeout", {31'd0, tick}, 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int gap;
  logic [W-1:0] frozen;

  initial begin
    model_reset();
    #2;
    check("reset_count", {28'd0, count}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    check("reset_wrap", {31'd0, wrap}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: divide by 4 counting up; first period includes the rate-change cycle
    en = 1'b1; rate_sel = 2'd2; up = 1'b1;
    wait_tick(gap);
    check("t1_first_gap", gap, 32'd5);
    check("t1_count1", {28'd0, count}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      wait_tick(gap);
      check("t1_gap", gap, 32'd4);
      check("t1_count", {28'd0, count}, k);
    end

    // 2: step up from all-ones
    load = 1'b1; load_val = 4'd15; cycle(); load = 1'b0;
    wait_tick(gap);
    check("t2_gap", gap, 32'd4);
`ifdef RATE_TICK_COUNTER_SAT_EN
    check("t2_count", {28'd0, count}, 32'd15);
`else
    check("t2_count", {28'd0, count}, 32'd0);
`endif
    check("t2_wrap", {31'd0, wrap}, 32'd1);
    cycle();
    check("t2_wrap_clear", {31'd0, wrap}, 32'd0);

    // 3: load on the terminal cycle wins over the step
    wait_tick(gap);
    run(3);
    load = 1'b1; load_val = 4'd9; cycle(); load = 1'b0;
    check("t3_load", {28'd0, count}, 32'd9);
    check("t3_no_tick", {31'd0, tick}, 32'd0);
    wait_tick(gap);
    check("t3_gap", gap, 32'd4);
    check("t3_count", {28'd0, count}, 32'd10);

    // 4: switch 3->1 at presc=5
    rate_sel = 2'd3; cycle();
    run(5);
    rate_sel = 2'd1; cycle();
    check("t4_no_tick", {31'd0, tick}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      wait_tick(gap);
      check("t4_gap", gap, 32'd2);
    end

    // 5: freeze mid-period, then finish the remaining period
    rate_sel = 2'd2; cycle();
    run(2);
    frozen = count;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t5_hold_tick", {31'd0, tick}, 32'd0);
      check("t5_hold_count", {28'd0, count}, {28'd0, frozen});
    end
    en = 1'b1;
    wait_tick(gap);
    check("t5_resume_gap", gap, 32'd2);

    // 6: asynchronous reset between edges, then step down from zero at DIV0=1
    reset = 1'b1;
    #2;
    check("t6_async_count", {28'd0, count}, 32'd0);
    check("t6_async_tick", {31'd0, tick}, 32'd0);
    model_reset();
    rate_sel = 2'd0; up = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle();
`ifdef RATE_TICK_COUNTER_SAT_EN
    check("t6_down_count", {28'd0, count}, 32'd0);
`else
    check("t6_down_count", {28'd0, count}, 32'd15);
`endif
    check("t6_down_wrap", {31'd0, wrap}, 32'd1);
    check("t6_tick", {31'd0, tick}, 32'd1);
    cycle();
    check("t6_tick_stays", {31'd0, tick}, 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) != 0);
      up = $urandom_range(0, 1) != 0;
      load = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) rate_sel = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
